// File: rtl/adbg_ahb3_pkg.sv
// Shared AHB-Lite constants for the adbg AHB3 slave blocks.
package adbg_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/adbg_ahb3_ram.sv
// Single-port storage array: per-byte write enable, asynchronous read.
// Contents are deliberately not reset.
module adbg_ahb3_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AW         = 8
) (
    input  logic                    clk_i,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Byte-lane writes on the rising edge.
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/adbg_ahb3_mem_slave.sv
// AHB-Lite memory slave: configurable wait states, two-cycle ERROR response
// for out-of-range, oversized or misaligned transfers.
module adbg_ahb3_mem_slave
    import adbg_ahb3_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            hreadyout_q;
    logic            hresp_q;
    logic            pend_q;
    logic            write_q;
    logic [AW-1:0]   idx_q;
    logic [LB-1:0]   lane_q;
    logic [2:0]      size_q;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [LB-1:0]         amask;
    logic                  req_err;
    logic [NB-1:0]         be;
    logic [NB-1:0]         ram_we;
    logic                  wr_commit;
    logic                  rd_complete;
    logic [DATA_WIDTH-1:0] ram_rdata;
    int unsigned           be_lo;
    int unsigned           be_hi;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    // Address-phase qualification and error classification.
    always_comb begin
        accept   = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
        word_idx = HADDR >> LB;
        amask    = '0;
        for (int unsigned i = 0; i < LB; i++) begin
            amask[i] = (32'(HSIZE) > i);
        end
        req_err  = (word_idx >= ADDR_WIDTH'(DEPTH))
                 | (HSIZE > 3'(LB))
                 | (|(HADDR[LB-1:0] & amask));
    end

    // Byte lanes touched by the latched offset and size (little-endian).
    always_comb begin
        be    = '0;
        be_lo = 32'(lane_q);
        be_hi = be_lo + (32'd1 << size_q);
        for (int unsigned b = 0; b < NB; b++) begin
            be[b] = (b >= be_lo) && (b < be_hi);
        end
    end

    // A data phase completes in IDLE while a transfer is pending with HREADYOUT high.
    assign wr_commit   = pend_q & write_q & hreadyout_q;
    assign rd_complete = pend_q & ~write_q & hreadyout_q;
    assign ram_we      = wr_commit ? be : '0;

    // Protocol FSM with registered HREADYOUT/HRESP and latched control.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            pend_q      <= 1'b0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            lane_q      <= '0;
            size_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR2: begin
                    if (accept) begin
                        write_q <= HWRITE;
                        idx_q   <= word_idx[AW-1:0];
                        lane_q  <= HADDR[LB-1:0];
                        size_q  <= HSIZE;
                        if (req_err) begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                            pend_q      <= 1'b0;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= S_WAIT;
                            cnt_q       <= 4'(WAIT_STATES);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_OKAY;
                            pend_q      <= 1'b1;
                        end else begin
                            state_q     <= S_IDLE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                            pend_q      <= 1'b1;
                        end
                    end else begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                        pend_q      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    pend_q      <= 1'b0;
                end
            endcase
        end
    end

    adbg_ahb3_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk_i   (HCLK),
        .we_i    (ram_we),
        .addr_i  (idx_q),
        .wdata_i (HWDATA),
        .rdata_o (ram_rdata)
    );

    assign HRDATA    = rd_complete ? ram_rdata : '0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_adbg_ahb3_mem_slave.sv
// Directed bench: u0 has no wait states, u1 has three; a shared bus with a
// per-slave select so only the DUT under test sees transfers.
module tb_adbg_ahb3_mem_slave;
    import adbg_ahb3_pkg::*;

    logic        clk;
    logic        rst0, rst1;
    logic        hsel, dsel;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;

    logic [31:0] hrdata0, hrdata1;
    logic        hreadyout0, hreadyout1, hresp0, hresp1;
    logic        cur_ready, cur_resp;
    logic [31:0] cur_rdata;

    int checks = 0;
    int errors = 0;

    assign cur_ready = dsel ? hreadyout1 : hreadyout0;
    assign cur_resp  = dsel ? hresp1     : hresp0;
    assign cur_rdata = dsel ? hrdata1    : hrdata0;

    adbg_ahb3_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESETn(rst0), .HSEL(hsel & ~dsel), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hreadyout0),
        .HREADYOUT(hreadyout0), .HRESP(hresp0));

    adbg_ahb3_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u1 (
        .HCLK(clk), .HRESETn(rst1), .HSEL(hsel & dsel), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hreadyout1),
        .HREADYOUT(hreadyout1), .HRESP(hresp1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = wr; haddr = a; hsize = sz;
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0; hsize = HSIZE_WORD;
    endtask

    // Returns at the negedge where the current DUT shows HREADYOUT=1.
    task automatic wait_done(output int lows, output logic tmo);
        lows = 0;
        @(negedge clk);
        while (!cur_ready && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        tmo = !cur_ready;
    endtask

    // Single OKAY write, then idle; checks latency and response.
    task automatic do_write(input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, input int exp_lows, input string nm);
        int   lows;
        logic tmo;
        drive_addr(1'b1, a, sz);
        @(posedge clk); #1;
        hwdata = d; drive_idle();
        wait_done(lows, tmo);
        checks++;
        if (tmo || lows !== exp_lows || cur_resp !== HRESP_OKAY) begin
            errors++;
            $display("FAIL %s wr lows=%0d resp=%b tmo=%b exp lows=%0d resp=0", nm, lows, cur_resp, tmo, exp_lows);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp,
                           input int exp_lows, input string nm);
        int   lows;
        logic tmo;
        drive_addr(1'b0, a, HSIZE_WORD);
        @(posedge clk); #1;
        drive_idle();
        wait_done(lows, tmo);
        checks++;
        if (tmo || lows !== exp_lows || cur_resp !== HRESP_OKAY || cur_rdata !== exp) begin
            errors++;
            $display("FAIL %s rd data=%h lows=%0d resp=%b exp data=%h lows=%0d resp=0",
                     nm, cur_rdata, lows, cur_resp, exp, exp_lows);
        end
        @(posedge clk); #1;
    endtask

    // Error transfer: ERR1 (ready 0, resp 1), ERR2 (ready 1, resp 1), then OKAY idle.
    task automatic do_error(input logic wr, input logic [31:0] a, input logic [2:0] sz, input string nm);
        drive_addr(wr, a, sz);
        @(posedge clk); #1;
        hwdata = 32'hFFFF_FFFF; drive_idle();
        @(negedge clk);
        checks++;
        if (cur_ready !== 1'b0 || cur_resp !== HRESP_ERROR) begin
            errors++;
            $display("FAIL %s err1 ready=%b resp=%b exp ready=0 resp=1", nm, cur_ready, cur_resp);
        end
        @(negedge clk);
        checks++;
        if (cur_ready !== 1'b1 || cur_resp !== HRESP_ERROR) begin
            errors++;
            $display("FAIL %s err2 ready=%b resp=%b exp ready=1 resp=1", nm, cur_ready, cur_resp);
        end
        @(negedge clk);
        checks++;
        if (cur_ready !== 1'b1 || cur_resp !== HRESP_OKAY) begin
            errors++;
            $display("FAIL %s after ready=%b resp=%b exp ready=1 resp=0", nm, cur_ready, cur_resp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b0; rst1 = 1'b0;
        dsel = 1'b0; drive_idle();
        hwdata = '0; hburst = '0; hprot = '0; hmastlock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hreadyout0 !== 1'b1 || hresp0 !== 1'b0 || hrdata0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_u0 ready=%b resp=%b rdata=%h exp 1 0 0", hreadyout0, hresp0, hrdata0);
        end
        checks++;
        if (hreadyout1 !== 1'b1 || hresp1 !== 1'b0 || hrdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_u1 ready=%b resp=%b rdata=%h exp 1 0 0", hreadyout1, hresp1, hrdata1);
        end
        rst0 = 1'b1; rst1 = 1'b1;
        @(posedge clk); #1;
    endtask

    // Back-to-back write then read of 0x10 with zero wait states.
    task automatic test_word_rw();
        int   lows;
        logic tmo;
        dsel = 1'b0;
        drive_addr(1'b1, 32'h10, HSIZE_WORD);
        @(posedge clk); #1;
        hwdata = 32'h1234_5678;
        drive_addr(1'b0, 32'h10, HSIZE_WORD);
        wait_done(lows, tmo);
        checks++;
        if (tmo || lows !== 0 || cur_resp !== 1'b0) begin
            errors++;
            $display("FAIL word_wr lows=%0d resp=%b exp lows=0 resp=0", lows, cur_resp);
        end
        @(posedge clk); #1;
        drive_idle();
        wait_done(lows, tmo);
        checks++;
        if (tmo || lows !== 0 || cur_resp !== 1'b0 || cur_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL word_rd data=%h lows=%0d resp=%b exp 12345678 0 0", cur_rdata, lows, cur_resp);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (cur_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rdata_idle got=%h exp=00000000", cur_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_write();
        dsel = 1'b0;
        do_write(32'h11, HSIZE_BYTE, 32'hFFFF_ABFF, 0, "byte_wr");
        do_read(32'h10, 32'h1234_AB78, 0, "byte_rd");
    endtask

    // Idle/busy or deselected transfers never touch memory.
    task automatic test_idle_busy();
        dsel = 1'b0;
        hsel = 1'b1; htrans = HTRANS_BUSY; hwrite = 1'b1; haddr = 32'h10; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hwdata = 32'h5555_5555;
        hsel = 1'b0; htrans = HTRANS_NONSEQ;
        @(negedge clk);
        checks++;
        if (cur_ready !== 1'b1 || cur_resp !== 1'b0) begin
            errors++;
            $display("FAIL busy_resp ready=%b resp=%b exp 1 0", cur_ready, cur_resp);
        end
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
        do_read(32'h10, 32'h1234_AB78, 0, "idle_noacc");
    endtask

    task automatic test_out_of_range();
        dsel = 1'b0;
        do_write(32'h0, HSIZE_WORD, 32'hCAFE_0001, 0, "oor_init");
        do_error(1'b1, 32'h400, HSIZE_WORD, "oor_wr");
        do_error(1'b0, 32'h400, HSIZE_WORD, "oor_rd");
        do_read(32'h0, 32'hCAFE_0001, 0, "oor_mem");
    endtask

    task automatic test_misaligned();
        dsel = 1'b0;
        do_error(1'b1, 32'h13, HSIZE_HWORD, "misalign");
        do_error(1'b0, 32'h10, HSIZE_DWORD, "oversize");
        do_read(32'h10, 32'h1234_AB78, 0, "misalign_mem");
    endtask

    // Three wait states, write immediately followed by read of the same word.
    task automatic test_back_to_back();
        int   lows;
        logic tmo;
        dsel = 1'b1;
        drive_addr(1'b1, 32'h20, HSIZE_WORD);
        @(posedge clk); #1;
        hwdata = 32'hDEAD_BEEF;
        drive_addr(1'b0, 32'h20, HSIZE_WORD);
        wait_done(lows, tmo);
        checks++;
        if (tmo || lows !== 3 || cur_resp !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wr lows=%0d resp=%b exp lows=3 resp=0", lows, cur_resp);
        end
        @(posedge clk); #1;
        drive_idle();
        wait_done(lows, tmo);
        checks++;
        if (tmo || lows !== 3 || cur_resp !== 1'b0 || cur_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_rd data=%h lows=%0d resp=%b exp deadbeef 3 0", cur_rdata, lows, cur_resp);
        end
        @(posedge clk); #1;
    endtask

    // Reset during the wait phase of a write aborts it with no commit.
    task automatic test_reset_abort();
        dsel = 1'b1;
        do_write(32'h30, HSIZE_WORD, 32'h1111_2222, 3, "abort_init");
        drive_addr(1'b1, 32'h30, HSIZE_WORD);
        @(posedge clk); #1;
        hwdata = 32'h9999_9999; drive_idle();
        @(negedge clk);
        checks++;
        if (hreadyout1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait ready=%b exp 0", hreadyout1);
        end
        #1 rst1 = 1'b0;
        #1;
        checks++;
        if (hreadyout1 !== 1'b1 || hresp1 !== 1'b0 || hrdata1 !== 32'h0) begin
            errors++;
            $display("FAIL abort_rst ready=%b resp=%b rdata=%h exp 1 0 0", hreadyout1, hresp1, hrdata1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk); #1;
        do_read(32'h30, 32'h1111_2222, 3, "abort_mem");
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_idle_busy();
        test_out_of_range();
        test_misaligned();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
